wfg_record_spi: RTL and testbench
=================================

WFG_RECORD_SPI -- requirements
Module: wfg_record_spi

Interface
REQ-001 The block SHALL have parameter AXIS_DATA_WIDTH, default 32: tdata width; only value 32 is supported.
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 4: output buffer entries, power of two; used only when WFG_RECORD_SPI_FIFO_EN is defined.
REQ-003 The block SHALL have these ports, name / direction / width / meaning:
- wb_clk_i  in  1  sole clock.
- wb_rst_i  in  1  reset; synchronous, active-high.
- cfg_en_i  in  1  receiver enable.
- cfg_cpol_i  in  1  SPI clock polarity.
- cfg_cpha_i  in  1  SPI clock phase.
- cfg_lsbfirst_i  in  1  bit order; 1 = LSB first.
- cfg_dff_i  in  2  word length: 0 = 8, 1 = 16, 2 = 24, 3 = 32 bits.
- wfg_record_spi_sclk_i  in  1  async SPI clock.
- wfg_record_spi_cs_ni  in  1  async chip select, active low.
- wfg_record_spi_sdi_i  in  1  async serial data.
- wfg_axis_tready_i  in  1  downstream ready.
- wfg_axis_tvalid_o  out  1  word valid.
- wfg_axis_tlast_o  out  1  last word of a CS frame.
- wfg_axis_tdata_o  out  32  received word.
- overflow_o  out  1  sticky: a word was dropped.
- frame_err_o  out  1  sticky: CS rose mid-word.

Function
REQ-004 sclk, cs_n and sdi SHALL each pass a 2-FF synchronizer plus one history flop; edges are detected on the synchronized signals only.
REQ-005 Correct capture SHALL be guaranteed for SCLK at or below wb_clk_i/4.
REQ-006 The sample edge SHALL be the rising SCLK edge when cfg_cpol_i == cfg_cpha_i, otherwise the falling edge.
REQ-007 The FSM SHALL have states IDLE and SHIFT.
- IDLE -> SHIFT on a synchronized cs_n falling edge while cfg_en_i = 1.
- SHIFT -> IDLE on a cs_n rising edge, or when cfg_en_i = 0.
REQ-008 In SHIFT, each sample edge SHALL shift in one sdi bit and increment a 5-bit bit counter.
REQ-009 When the counter reaches N-1 (N = word length), the assembled word SHALL move to a pending register, and the counter SHALL wrap to 0 in that same cycle.
REQ-010 Bit placement: with MSB first, the first received bit SHALL land at tdata[N-1]; with LSB first, at tdata[0]; tdata[31:N] SHALL be 0.
REQ-011 A pending word SHALL be pushed:
- with tlast = 0 on the next sample edge;
- with tlast = 1 on a cs_n rising edge.
If both occur in the same cycle, cs_n takes precedence.
REQ-012 A cs_n rise while the counter is nonzero SHALL discard the partial bits and set frame_err_o; any pending word is still pushed with tlast = 1.
REQ-013 AXI-stream rules:
- tvalid_o, once high, SHALL remain high with tdata_o and tlast_o stable until a cycle with tready_i = 1.
- A push into a full output stage SHALL drop the new word and set overflow_o.
REQ-014 Latency SHALL be 5 wb_clk_i cycles or less from the synchronized sample or CS edge to tvalid_o, when the output stage is empty.
REQ-015 Config inputs SHALL be sampled only on the IDLE -> SHIFT transition; changes during SHIFT take effect at the next frame.
REQ-016 With cfg_en_i = 0:
- the FSM SHALL return to IDLE and clear the pending register;
- overflow_o and frame_err_o SHALL be cleared;
- words already in the output stage SHALL remain deliverable.

Reset
REQ-017 On wb_rst_i = 1 at a wb_clk_i edge:
- the FSM SHALL go to IDLE;
- counter, shift, pending and output state SHALL clear;
- all outputs SHALL be 0.
Synchronizer flops SHALL reset to cs_n = 1, and to sclk = cfg_cpol_i idle level.
REQ-018 Reset asserted mid-frame SHALL discard all data; after release, the receiver SHALL wait for a fresh cs_n falling edge.

Configuration
REQ-019 With WFG_RECORD_SPI_FIFO_EN defined, the output stage SHALL be a FIFO_DEPTH-entry FIFO of {tlast, tdata}. Full means FIFO_DEPTH entries are held.
REQ-020 Without WFG_RECORD_SPI_FIFO_EN, the output stage SHALL be a single register slice. Full means tvalid_o = 1 and tready_i = 0.

Structure
REQ-021 Package wfg_record_spi_pkg SHALL hold:
- the FSM state enum (IDLE, SHIFT);
- the cfg_dff_i encoding and its word-length lookup;
- SYNC_STAGES = 2.
REQ-022 The output stage SHALL be sub-module wfg_record_spi_fifo, parameterised by depth; depth 1 is used when the macro is undefined.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- Mode 0, MSB first, 8 bits: one frame sending 0xA5 -> a single beat with tdata = 0x000000A5, tlast = 1.
- Mode 3, LSB first, 16 bits: frame sending 0x1234 then 0xBEEF -> beats 0x1234 (tlast = 0) and 0xBEEF (tlast = 1).
- Mode 1, 32 bits: 0xDEADBEEF with tready held 0 for 200 cycles -> tvalid stays high and the data is stable until accepted.
- 8 bits: CS raised after 5 bits -> no beat and frame_err_o = 1; a following 0x3C frame -> beat 0x3C.
- tready = 0 while sending more words than the output stage holds -> overflow_o = 1, and the stored words are delivered in order. Run both with and without WFG_RECORD_SPI_FIFO_EN.
- wb_rst_i pulsed after 12 bits of a 24-bit word -> all outputs 0, no beat; the next full frame 0xC0FFEE -> beat 0x00C0FFEE.

Source files
------------

// File: rtl/wfg_record_spi_pkg.sv
// wfg_record_spi_pkg: shared FSM state, word-length encoding and
// synchronizer depth for the SPI recorder.
package wfg_record_spi_pkg;

   localparam int SYNC_STAGES = 2;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   typedef enum logic [1:0] {
      DFF_8  = 2'd0,
      DFF_16 = 2'd1,
      DFF_24 = 2'd2,
      DFF_32 = 2'd3
   } dff_t;

   // Index of the last bit of a word (word length minus one).
   function automatic logic [4:0] word_last_bit(input dff_t dff);
      logic [4:0] last;
      case (dff)
         DFF_8:   last = 5'd7;
         DFF_16:  last = 5'd15;
         DFF_24:  last = 5'd23;
         default: last = 5'd31;
      endcase
      return last;
   endfunction

endpackage

// File: rtl/wfg_record_spi_fifo.sv
// wfg_record_spi_fifo: output stage. DEPTH == 1 is a register slice that
// can reload in the cycle it is drained; larger depths are a plain FIFO
// that is full when DEPTH entries are held.
module wfg_record_spi_fifo #(
   parameter int DEPTH = 1,
   parameter int WIDTH = 33
) (
   input  logic             clk,
   input  logic             srst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   output logic             full
);

   generate
      if (DEPTH == 1) begin : g_slice
         logic             valid_reg;
         logic [WIDTH-1:0] data_reg;

         assign full      = valid_reg && !pop_ready;
         assign out_valid = valid_reg;
         assign out_data  = data_reg;

         // Single-entry slice: load when empty or being drained, else hold.
         always_ff @(posedge clk) begin
            if (srst) begin
               valid_reg <= 1'b0;
               data_reg  <= '0;
            end else if (push && !full) begin
               valid_reg <= 1'b1;
               data_reg  <= push_data;
            end else if (valid_reg && pop_ready) begin
               valid_reg <= 1'b0;
            end
         end
      end else begin : g_fifo
         localparam int AW = $clog2(DEPTH);
         localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

         logic [WIDTH-1:0] mem [DEPTH];
         logic [AW-1:0]    wr_ptr_reg;
         logic [AW-1:0]    rd_ptr_reg;
         logic [AW:0]      count_reg;
         logic             push_ok;
         logic             pop;

         assign full      = (count_reg == CNT_FULL);
         assign out_valid = (count_reg != '0);
         assign push_ok   = push && !full;
         assign pop       = out_valid && pop_ready;
         assign out_data  = out_valid ? mem[rd_ptr_reg] : '0;

         // Storage array, written at the tail.
         always_ff @(posedge clk) begin
            if (push_ok) begin
               mem[wr_ptr_reg] <= push_data;
            end
         end

         // Pointers wrap naturally because DEPTH is a power of two.
         always_ff @(posedge clk) begin
            if (srst) begin
               wr_ptr_reg <= '0;
               rd_ptr_reg <= '0;
               count_reg  <= '0;
            end else begin
               if (push_ok) begin
                  wr_ptr_reg <= wr_ptr_reg + AW'(1);
               end
               if (pop) begin
                  rd_ptr_reg <= rd_ptr_reg + AW'(1);
               end
               case ({push_ok, pop})
                  2'b10:   count_reg <= count_reg + (AW+1)'(1);
                  2'b01:   count_reg <= count_reg - (AW+1)'(1);
                  default: count_reg <= count_reg;
               endcase
            end
         end
      end
   endgenerate

endmodule

// File: rtl/wfg_record_spi.sv
// wfg_record_spi: SPI slave receiver that turns CS-framed serial words into
// AXI-stream beats (tlast marks the final word of a frame).
// Define WFG_RECORD_SPI_FIFO_EN to use a FIFO_DEPTH-entry output FIFO;
// otherwise the output stage is a single register slice.
module wfg_record_spi #(
   parameter int AXIS_DATA_WIDTH = 32,
   parameter int FIFO_DEPTH      = 4
) (
   input  logic                       wb_clk_i,
   input  logic                       wb_rst_i,
   input  logic                       cfg_en_i,
   input  logic                       cfg_cpol_i,
   input  logic                       cfg_cpha_i,
   input  logic                       cfg_lsbfirst_i,
   input  logic [1:0]                 cfg_dff_i,
   input  logic                       wfg_record_spi_sclk_i,
   input  logic                       wfg_record_spi_cs_ni,
   input  logic                       wfg_record_spi_sdi_i,
   input  logic                       wfg_axis_tready_i,
   output logic                       wfg_axis_tvalid_o,
   output logic                       wfg_axis_tlast_o,
   output logic [AXIS_DATA_WIDTH-1:0] wfg_axis_tdata_o,
   output logic                       overflow_o,
   output logic                       frame_err_o
);
   import wfg_record_spi_pkg::*;

`ifdef WFG_RECORD_SPI_FIFO_EN
   localparam bit FIFO_EN = 1'b1;
`else
   localparam bit FIFO_EN = 1'b0;
`endif
   localparam int OUT_DEPTH = FIFO_EN ? FIFO_DEPTH : 1;
   localparam int B_CS = 2, B_SCLK = 1, B_SDI = 0;

   // Synchronizer chains: stages 0..SYNC_STAGES-1 resolve metastability,
   // stage SYNC_STAGES is the history flop for edge detection.
   logic [2:0]           stage_reg [SYNC_STAGES+1];
   logic [2:0]           sync_rst_val;
   logic [SYNC_STAGES:0] primed_reg;
   logic                 primed, cs_rise, cs_fall, sclk_rise, sclk_fall, sample_edge, sdi_bit;

   assign sync_rst_val = {1'b1, cfg_cpol_i, 1'b0};

   // Shift the async inputs through the chain; primed_reg tracks when every
   // stage holds a real sample so reset values never look like an edge.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         for (int s = 0; s <= SYNC_STAGES; s++) stage_reg[s] <= sync_rst_val;
         primed_reg <= '0;
      end else begin
         stage_reg[0] <= {wfg_record_spi_cs_ni, wfg_record_spi_sclk_i, wfg_record_spi_sdi_i};
         for (int s = 1; s <= SYNC_STAGES; s++) stage_reg[s] <= stage_reg[s-1];
         primed_reg <= {primed_reg[SYNC_STAGES-1:0], 1'b1};
      end
   end

   assign primed    = primed_reg[SYNC_STAGES];
   assign cs_fall   = primed &  stage_reg[SYNC_STAGES][B_CS]   & ~stage_reg[SYNC_STAGES-1][B_CS];
   assign cs_rise   = primed & ~stage_reg[SYNC_STAGES][B_CS]   &  stage_reg[SYNC_STAGES-1][B_CS];
   assign sclk_fall = primed &  stage_reg[SYNC_STAGES][B_SCLK] & ~stage_reg[SYNC_STAGES-1][B_SCLK];
   assign sclk_rise = primed & ~stage_reg[SYNC_STAGES][B_SCLK] &  stage_reg[SYNC_STAGES-1][B_SCLK];
   // Data is taken from the sample just before the detected clock edge.
   assign sdi_bit   = stage_reg[SYNC_STAGES][B_SDI];

   state_t                     state_reg, state_next;
   dff_t                       dff_reg, dff_next;
   logic                       sample_rise_reg, sample_rise_next;
   logic                       lsb_reg, lsb_next;
   logic [4:0]                 cnt_reg, cnt_next, last_bit, bit_idx;
   logic [AXIS_DATA_WIDTH-1:0] shift_reg, shift_next, pend_reg, pend_next, word_asm;
   logic                       pend_valid_reg, pend_valid_next;
   logic                       overflow_reg, overflow_next, frame_err_reg, frame_err_next;
   logic                       stage_push, stage_last, stage_full;
   logic [AXIS_DATA_WIDTH:0]   stage_data;

   assign sample_edge = sample_rise_reg ? sclk_rise : sclk_fall;
   assign last_bit    = word_last_bit(dff_reg);
   assign bit_idx     = lsb_reg ? cnt_reg : (last_bit - cnt_reg);

   // Receiver state register; config is held here for the whole frame.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state_reg       <= IDLE;
         dff_reg         <= DFF_8;
         sample_rise_reg <= 1'b1;
         lsb_reg         <= 1'b0;
         cnt_reg         <= '0;
         shift_reg       <= '0;
         pend_reg        <= '0;
         pend_valid_reg  <= 1'b0;
         overflow_reg    <= 1'b0;
         frame_err_reg   <= 1'b0;
      end else begin
         state_reg       <= state_next;
         dff_reg         <= dff_next;
         sample_rise_reg <= sample_rise_next;
         lsb_reg         <= lsb_next;
         cnt_reg         <= cnt_next;
         shift_reg       <= shift_next;
         pend_reg        <= pend_next;
         pend_valid_reg  <= pend_valid_next;
         overflow_reg    <= overflow_next;
         frame_err_reg   <= frame_err_next;
      end
   end

   // Next-state, bit assembly and push decisions.
   always_comb begin
      state_next        = state_reg;
      dff_next          = dff_reg;
      sample_rise_next  = sample_rise_reg;
      lsb_next          = lsb_reg;
      cnt_next          = cnt_reg;
      shift_next        = shift_reg;
      pend_next         = pend_reg;
      pend_valid_next   = pend_valid_reg;
      overflow_next     = overflow_reg;
      frame_err_next    = frame_err_reg;
      stage_push        = 1'b0;
      stage_last        = 1'b0;
      word_asm          = shift_reg;
      word_asm[bit_idx] = sdi_bit;
      case (state_reg)
         IDLE: begin
            if (cfg_en_i && cs_fall) begin
               state_next       = SHIFT;
               dff_next         = dff_t'(cfg_dff_i);
               sample_rise_next = (cfg_cpol_i == cfg_cpha_i);
               lsb_next         = cfg_lsbfirst_i;
               cnt_next         = '0;
               shift_next       = '0;
               pend_valid_next  = 1'b0;
            end
         end
         SHIFT: begin
            if (!cfg_en_i) begin
               state_next      = IDLE;
               cnt_next        = '0;
               shift_next      = '0;
               pend_next       = '0;
               pend_valid_next = 1'b0;
            end else if (cs_rise) begin
               // End of frame wins over a coincident sample edge.
               state_next      = IDLE;
               cnt_next        = '0;
               shift_next      = '0;
               pend_valid_next = 1'b0;
               stage_push      = pend_valid_reg;
               stage_last      = 1'b1;
               if (cnt_reg != '0) frame_err_next = 1'b1;
            end else if (sample_edge) begin
               stage_push      = pend_valid_reg;
               pend_valid_next = 1'b0;
               if (cnt_reg == last_bit) begin
                  pend_next       = word_asm;
                  pend_valid_next = 1'b1;
                  cnt_next        = '0;
                  shift_next      = '0;
               end else begin
                  shift_next = word_asm;
                  cnt_next   = cnt_reg + 5'd1;
               end
            end
         end
         default: state_next = IDLE;
      endcase
      if (stage_push && stage_full) overflow_next = 1'b1;
      if (!cfg_en_i) begin
         overflow_next  = 1'b0;
         frame_err_next = 1'b0;
      end
   end

   wfg_record_spi_fifo #(
      .DEPTH (OUT_DEPTH),
      .WIDTH (AXIS_DATA_WIDTH + 1)
   ) u_out (
      .clk       (wb_clk_i),
      .srst      (wb_rst_i),
      .push      (stage_push),
      .push_data ({stage_last, pend_reg}),
      .pop_ready (wfg_axis_tready_i),
      .out_valid (wfg_axis_tvalid_o),
      .out_data  (stage_data),
      .full      (stage_full)
   );

   assign wfg_axis_tdata_o = stage_data[AXIS_DATA_WIDTH-1:0];
   assign wfg_axis_tlast_o = stage_data[AXIS_DATA_WIDTH];
   assign overflow_o       = overflow_reg;
   assign frame_err_o      = frame_err_reg;

endmodule

// File: tb/tb_wfg_record_spi.sv
// tb_wfg_record_spi: directed bench for wfg_record_spi. Acts as SPI master,
// collects accepted AXI-stream beats and checks them against hand values.
// Build with or without WFG_RECORD_SPI_FIFO_EN.
module tb_wfg_record_spi;
`ifdef WFG_RECORD_SPI_FIFO_EN
   localparam int DEPTH = 4;
`else
   localparam int DEPTH = 1;
`endif
   localparam int HALF = 4;   // SCLK half period in clk cycles

   logic        clk = 1'b0;
   logic        rst, en, cpol, cpha, lsb;
   logic [1:0]  dff;
   logic        sclk, cs_n, sdi, tready;
   logic        tvalid, tlast, overflow, frame_err;
   logic [31:0] tdata;
   int          vectors = 0;
   int          miscompares = 0;
   logic [32:0] beats [$];

   always #5 clk = ~clk;

   wfg_record_spi dut (
      .wb_clk_i              (clk),
      .wb_rst_i              (rst),
      .cfg_en_i              (en),
      .cfg_cpol_i            (cpol),
      .cfg_cpha_i            (cpha),
      .cfg_lsbfirst_i        (lsb),
      .cfg_dff_i             (dff),
      .wfg_record_spi_sclk_i (sclk),
      .wfg_record_spi_cs_ni  (cs_n),
      .wfg_record_spi_sdi_i  (sdi),
      .wfg_axis_tready_i     (tready),
      .wfg_axis_tvalid_o     (tvalid),
      .wfg_axis_tlast_o      (tlast),
      .wfg_axis_tdata_o      (tdata),
      .overflow_o            (overflow),
      .frame_err_o           (frame_err)
   );

   // Record each beat that will be accepted at the next rising edge.
   always @(negedge clk) begin
      if (tvalid === 1'b1 && tready === 1'b1) begin
         beats.push_back({tlast, tdata});
         $display("[%0t] beat tdata=%08h tlast=%0d", $time, tdata, tlast);
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
      $display("[%0t] %s observed=%0h expected=%0h", $time, tag, obs, exp);
   endtask

   task automatic half();
      repeat (HALF) @(negedge clk);
   endtask

   task automatic set_ready(input logic v);
      @(posedge clk);
      #2 tready = v;
   endtask

   task automatic spi_config(input logic pol, input logic pha, input logic l, input logic [1:0] d);
      cpol = pol; cpha = pha; lsb = l; dff = d; sclk = pol;
      half();
   endtask

   task automatic cs_low();
      cs_n = 1'b0;
      half();
   endtask

   task automatic cs_high();
      half();
      cs_n = 1'b1;
      half();
      half();
   endtask

   // Shift nbits of word out in the configured mode and bit order.
   task automatic spi_bits(input logic [31:0] word, input int nbits);
      for (int k = 0; k < nbits; k++) begin
         logic b;
         b = lsb ? word[k] : word[nbits-1-k];
         if (!cpha) begin
            sdi = b; half();
            sclk = ~cpol; half();
            sclk = cpol;
         end else begin
            sclk = ~cpol; sdi = b; half();
            sclk = cpol; half();
         end
      end
   endtask

   task automatic expect_beat(input string tag, input logic [31:0] data, input logic last);
      logic [32:0] b;
      int t;
      t = 0;
      while (beats.size() == 0 && t < 300) begin
         @(negedge clk);
         t++;
      end
      vectors++;
      assert (beats.size() != 0) else begin
         miscompares++;
         $error("FAIL %s: no beat after %0d cycles, expected tdata %08h", tag, t, data);
      end
      if (beats.size() != 0) begin
         b = beats.pop_front();
         check({tag, " tdata"}, 64'(b[31:0]), 64'(data));
         check({tag, " tlast"}, 64'(b[32]), 64'(last));
      end
   endtask

   initial begin
      logic        stable;
      int          t;
      rst = 1'b1; en = 1'b1; cpol = 1'b0; cpha = 1'b0; lsb = 1'b0; dff = 2'd0;
      sclk = 1'b0; cs_n = 1'b1; sdi = 1'b0; tready = 1'b1;
      repeat (4) @(negedge clk);
      check("reset tvalid", 64'(tvalid), 64'd0);
      check("reset tlast", 64'(tlast), 64'd0);
      check("reset tdata", 64'(tdata), 64'd0);
      check("reset overflow", 64'(overflow), 64'd0);
      check("reset frame_err", 64'(frame_err), 64'd0);
      rst = 1'b0;
      repeat (4) @(negedge clk);

      // Mode 0, MSB first, 8 bits.
      spi_config(1'b0, 1'b0, 1'b0, 2'd0);
      cs_low(); spi_bits(32'hA5, 8); cs_high();
      expect_beat("m0 a5", 32'h0000_00A5, 1'b1);
      repeat (10) @(negedge clk);
      check("m0 extra beats", 64'(beats.size()), 64'd0);

      // Mode 3, LSB first, 16 bits, two words.
      spi_config(1'b1, 1'b1, 1'b1, 2'd1);
      cs_low(); spi_bits(32'h1234, 16); spi_bits(32'hBEEF, 16); cs_high();
      expect_beat("m3 w0", 32'h0000_1234, 1'b0);
      expect_beat("m3 w1", 32'h0000_BEEF, 1'b1);

      // Mode 1, 32 bits, backpressure for 200 cycles.
      set_ready(1'b0);
      spi_config(1'b0, 1'b1, 1'b0, 2'd3);
      cs_low(); spi_bits(32'hDEAD_BEEF, 32); cs_high();
      t = 0;
      while (tvalid !== 1'b1 && t < 100) begin
         @(negedge clk);
         t++;
      end
      check("m1 tvalid", 64'(tvalid), 64'd1);
      check("m1 tdata", 64'(tdata), 64'hDEAD_BEEF);
      check("m1 tlast", 64'(tlast), 64'd1);
      stable = 1'b1;
      repeat (200) begin
         @(negedge clk);
         if (tvalid !== 1'b1 || tdata !== 32'hDEAD_BEEF || tlast !== 1'b1) stable = 1'b0;
      end
      check("m1 held stable", 64'(stable), 64'd1);
      check("m1 no accept", 64'(beats.size()), 64'd0);
      set_ready(1'b1);
      expect_beat("m1 deadbeef", 32'hDEAD_BEEF, 1'b1);

      // Aborted word: CS rises after 5 of 8 bits, then a clean 0x3C frame.
      spi_config(1'b0, 1'b0, 1'b0, 2'd0);
      cs_low(); spi_bits(32'h16, 5); cs_high();
      check("abort frame_err", 64'(frame_err), 64'd1);
      check("abort no beat", 64'(beats.size()), 64'd0);
      cs_low(); spi_bits(32'h3C, 8); cs_high();
      expect_beat("after abort 3c", 32'h0000_003C, 1'b1);
      check("frame_err sticky", 64'(frame_err), 64'd1);
      en = 1'b0;
      repeat (2) @(negedge clk);
      check("disable clears frame_err", 64'(frame_err), 64'd0);
      en = 1'b1;
      repeat (2) @(negedge clk);

      // Overflow: more words than the output stage holds while tready = 0.
      set_ready(1'b0);
      spi_config(1'b0, 1'b0, 1'b0, 2'd0);
      cs_low();
      for (int i = 0; i < DEPTH + 2; i++) spi_bits(32'h11 * (i + 1), 8);
      cs_high();
      check("overflow set", 64'(overflow), 64'd1);
      check("overflow no accept", 64'(beats.size()), 64'd0);
      set_ready(1'b1);
      for (int i = 0; i < DEPTH; i++) expect_beat("overflow word", 32'h11 * (i + 1), 1'b0);
      repeat (20) @(negedge clk);
      check("overflow extra beats", 64'(beats.size()), 64'd0);

      // Reset pulse after 12 of 24 bits; overflow is still set going in.
      spi_config(1'b0, 1'b0, 1'b0, 2'd2);
      cs_low(); spi_bits(32'hABC, 12);
      @(negedge clk) rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("midreset tvalid", 64'(tvalid), 64'd0);
      check("midreset tlast", 64'(tlast), 64'd0);
      check("midreset tdata", 64'(tdata), 64'd0);
      check("midreset overflow", 64'(overflow), 64'd0);
      check("midreset frame_err", 64'(frame_err), 64'd0);
      spi_bits(32'hDEF, 12); cs_high();
      check("midreset no beat", 64'(beats.size()), 64'd0);
      check("midreset no frame_err", 64'(frame_err), 64'd0);
      cs_low(); spi_bits(32'hC0FFEE, 24); cs_high();
      expect_beat("after reset c0ffee", 32'h00C0_FFEE, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
